// File: rtl/rsc_pkg.sv
// Shared constants and the position-to-digit mapping for the rotating-square display.
package rsc_pkg;

  localparam int POS_W      = 3;
  localparam int NUM_DIGITS = 4;
  localparam int DIG_W      = 2;

  // Active-low segment patterns, bit order g,f,e,d,c,b,a.
  localparam logic [6:0] SEG_UPPER = 7'b0011100;
  localparam logic [6:0] SEG_LOWER = 7'b0100011;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef struct packed {
    logic [DIG_W-1:0] digit;
    logic [6:0]       pattern;
  } square_t;

  // Top row runs from the left digit rightwards, bottom row back leftwards.
  function automatic square_t pos_to_square(input logic [POS_W-1:0] pos);
    square_t sq;
    if (!pos[2]) begin
      sq.digit   = 2'd3 - pos[1:0];
      sq.pattern = SEG_UPPER;
    end else begin
      sq.digit   = pos[1:0];
      sq.pattern = SEG_LOWER;
    end
    return sq;
  endfunction

endpackage

// File: rtl/sseg_scan_mux.sv
// Free-running digit scanner with registered anode/segment outputs.
module sseg_scan_mux
  import rsc_pkg::*;
#(
  parameter int SCAN_BITS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIG_W-1:0] i_sq_digit,
  input  logic [6:0]       i_sq_pattern,
  output logic [3:0]       o_an,
  output logic [6:0]       o_sseg
);

  logic [SCAN_BITS-1:0] r_scan_cnt;
  logic [3:0]           r_an;
  logic [6:0]           r_sseg;
  logic [DIG_W-1:0]     w_sel;
  logic [3:0]           w_an;

  assign w_sel = r_scan_cnt[SCAN_BITS-1 -: DIG_W];

  // NOTE: the default assignment before the indexed write keeps this purely combinational (no latch).
  always_comb begin
    w_an        = '1;
    w_an[w_sel] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scan_cnt <= '0;
      r_an       <= '1;
      r_sseg     <= SEG_BLANK;
    end else begin
      r_scan_cnt <= r_scan_cnt + SCAN_BITS'(1);
      r_an       <= w_an;
      r_sseg     <= (w_sel == i_sq_digit) ? i_sq_pattern : SEG_BLANK;
    end
  end

  assign o_an   = r_an;
  assign o_sseg = r_sseg;

endmodule

// File: rtl/rsc_controller.sv
// Rotating-square sequencer: step-rate counter, square position, and display scan.
module rsc_controller
  import rsc_pkg::*;
#(
  parameter int SCAN_BITS = 16,
  parameter int STEP_CNT  = 2_000_000,
  parameter int STEP_BITS = 21
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cw,
  output logic [3:0]       an,
  output logic [6:0]       sseg,
  output logic [POS_W-1:0] pos,
  output logic             step_tick
);

  localparam logic [STEP_BITS-1:0] STEP_LAST = STEP_BITS'(STEP_CNT - 1);

  logic [STEP_BITS-1:0] r_step_cnt;
  logic [POS_W-1:0]     r_pos;
  logic                 r_step_tick;
  logic                 w_step_done;
  square_t              w_sq;

  assign w_step_done = en && (r_step_cnt == STEP_LAST);

  // Pausing freezes the partial count; cw only matters on the update cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_step_cnt  <= '0;
      r_pos       <= '0;
      r_step_tick <= 1'b0;
    end else begin
      r_step_tick <= w_step_done;
      if (w_step_done) begin
        r_step_cnt <= '0;
        r_pos      <= cw ? r_pos + POS_W'(1) : r_pos - POS_W'(1);
      end else if (en) begin
        r_step_cnt <= r_step_cnt + STEP_BITS'(1);
      end
    end
  end

  // Mapping uses the registered pos, so a step lands on the pins one cycle later.
  assign w_sq = pos_to_square(r_pos);

  sseg_scan_mux #(
    .SCAN_BITS (SCAN_BITS)
  ) u_scan (
    .clk          (clk),
    .reset        (reset),
    .i_sq_digit   (w_sq.digit),
    .i_sq_pattern (w_sq.pattern),
    .o_an         (an),
    .o_sseg       (sseg)
  );

  assign pos       = r_pos;
  assign step_tick = r_step_tick;

endmodule

// File: tb/tb_rsc_controller.sv
// Self-checking bench for rsc_controller with SCAN_BITS=4, STEP_CNT=4.
module tb_rsc_controller;

  localparam logic [6:0] UPPER = 7'b0011100;
  localparam logic [6:0] LOWER = 7'b0100011;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset, en, cw;
  logic [3:0] an;
  logic [6:0] sseg;
  logic [2:0] pos;
  logic       step_tick;

  rsc_controller #(
    .SCAN_BITS (4),
    .STEP_CNT  (4),
    .STEP_BITS (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .cw        (cw),
    .an        (an),
    .sseg      (sseg),
    .pos       (pos),
    .step_tick (step_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] sseg;
    logic [2:0] pos;
    logic       tick;
  } exp_t;

  typedef struct {
    int         cycles;
    logic       rst;
    logic       en;
    logic       cw;
    logic [2:0] exp_pos;
    logic       exp_tick;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  logic [3:0] m_scan;
  int         m_step;
  logic [2:0] m_pos;
  logic       m_tick;
  logic [3:0] m_an;
  logic [6:0] m_sseg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [1:0] square_digit(input logic [2:0] p);
    case (p)
      3'd0: return 2'd3;
      3'd1: return 2'd2;
      3'd2: return 2'd1;
      3'd3: return 2'd0;
      3'd4: return 2'd0;
      3'd5: return 2'd1;
      3'd6: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Drive one clock of stimulus, predict the post-edge outputs, compare after the edge.
  task automatic cycle(input logic r, input logic e, input logic c);
    exp_t       x;
    logic [1:0] sel;
    reset = r;
    en    = e;
    cw    = c;
    if (r) begin
      m_scan = '0;
      m_step = 0;
      m_pos  = '0;
      m_tick = 1'b0;
      m_an   = 4'hF;
      m_sseg = BLANK;
    end else begin
      sel         = m_scan[3:2];
      m_an        = 4'hF;
      m_an[sel]   = 1'b0;
      m_sseg      = (square_digit(m_pos) == sel) ? ((m_pos < 3'd4) ? UPPER : LOWER) : BLANK;
      m_scan      = m_scan + 4'd1;
      m_tick      = 1'b0;
      if (e) begin
        if (m_step == 3) begin
          m_step = 0;
          m_tick = 1'b1;
          m_pos  = c ? m_pos + 3'd1 : m_pos - 3'd1;
        end else begin
          m_step++;
        end
      end
    end
    x.an = m_an; x.sseg = m_sseg; x.pos = m_pos; x.tick = m_tick;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    check("sb_an",   32'(an),        32'(x.an));
    check("sb_sseg", 32'(sseg),      32'(x.sseg));
    check("sb_pos",  32'(pos),       32'(x.pos));
    check("sb_tick", 32'(step_tick), 32'(x.tick));
  endtask

  task automatic run_until_an(input logic [3:0] target, input logic e, input logic c, input int budget);
    int n = 0;
    while (an !== target && n < budget) begin
      cycle(1'b0, e, c);
      n++;
    end
    check("an_reached", 32'(an), 32'(target));
  endtask

  task automatic add(input int n, input logic r, input logic e, input logic c,
                     input logic [2:0] p, input logic t);
    vec_t v;
    v.cycles = n; v.rst = r; v.en = e; v.cw = c; v.exp_pos = p; v.exp_tick = t;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; en = 1'b0; cw = 1'b1;

    // Reset state and first post-release cycle
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1);
    check("rst_an",   32'(an),        32'hF);
    check("rst_sseg", 32'(sseg),      32'h7F);
    check("rst_pos",  32'(pos),       32'd0);
    check("rst_tick", 32'(step_tick), 32'd0);
    cycle(1'b0, 1'b0, 1'b1);
    check("first_an",   32'(an),   32'(4'b1110));
    check("first_sseg", 32'(sseg), 32'(BLANK));
    run_until_an(4'b0111, 1'b0, 1'b1, 20);
    check("pos0_upper", 32'(sseg), 32'(UPPER));

    // Phase table: {cycles, reset, en, cw, pos after, step_tick after}
    add(3,  1, 0, 1, 3'd0, 0);
    add(4,  0, 1, 1, 3'd1, 1);
    add(4,  0, 1, 1, 3'd2, 1);
    add(12, 0, 1, 1, 3'd5, 1);
    add(3,  0, 1, 1, 3'd5, 0);
    add(1,  0, 1, 1, 3'd6, 1);
    add(8,  0, 1, 1, 3'd0, 1);   // wraps 7 -> 0
    add(3,  1, 1, 1, 3'd0, 0);
    add(4,  0, 1, 0, 3'd7, 1);   // ccw wraps 0 -> 7
    add(4,  0, 1, 0, 3'd6, 1);
    add(2,  0, 1, 0, 3'd6, 0);   // step count now 2
    add(10, 0, 0, 0, 3'd6, 0);   // paused
    add(1,  0, 1, 0, 3'd6, 0);
    add(1,  0, 1, 0, 3'd5, 1);   // held count resumes: 2 cycles
    add(2,  0, 1, 0, 3'd5, 0);
    add(1,  0, 1, 1, 3'd5, 0);   // cw flips one cycle before terminal count
    add(1,  0, 1, 1, 3'd6, 1);
    add(3,  0, 1, 1, 3'd6, 0);
    add(1,  0, 1, 1, 3'd7, 1);
    add(3,  0, 1, 0, 3'd7, 0);
    add(1,  0, 1, 0, 3'd6, 1);
    add(3,  0, 1, 0, 3'd6, 0);   // pos 6, step count 3
    add(1,  1, 1, 0, 3'd0, 0);   // reset mid-step
    add(3,  0, 1, 1, 3'd0, 0);
    add(1,  0, 1, 1, 3'd1, 1);   // first step 4 cycles after release

    foreach (vecs[k]) begin
      for (int i = 0; i < vecs[k].cycles; i++) cycle(vecs[k].rst, vecs[k].en, vecs[k].cw);
      check($sformatf("vec%0d_pos", k),  32'(pos),       32'(vecs[k].exp_pos));
      check($sformatf("vec%0d_tick", k), 32'(step_tick), 32'(vecs[k].exp_tick));
      if (vecs[k].rst) check($sformatf("vec%0d_rst_an", k), 32'(an), 32'hF);
    end

    // Lower pattern at pos 5 on digit 1
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b1);
    check("cw_pos5", 32'(pos), 32'd5);
    run_until_an(4'b1101, 1'b0, 1'b1, 20);
    check("pos5_lower", 32'(sseg), 32'(LOWER));

    // Counter-clockwise first step lands on pos 7, lower pattern on digit 3
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0);
    check("ccw_pos7", 32'(pos), 32'd7);
    run_until_an(4'b0111, 1'b0, 1'b0, 20);
    check("pos7_lower", 32'(sseg), 32'(LOWER));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
